zx_mem_pager: RTL



---
 rtl/zx_mem_pkg.sv | 26 ++
 rtl/zx_mem_pager_if.sv | 35 +++
 rtl/zx_wait_gen.sv | 63 ++++++
 rtl/zx_mem_pager.sv | 106 ++++++++++
 4 files changed

// File: rtl/zx_mem_pkg.sv
// Shared types and constants for the Z80 memory pager: data-bus source
// encoding, port decode mask, fixed bank numbers and paging-latch fields.
package zx_mem_pkg;

  typedef enum logic [1:0] {
    DB_FLOAT = 2'd0,
    DB_ROM   = 2'd1,
    DB_RAM   = 2'd2,
    DB_FF    = 2'd3
  } dbus_sel_e;

  // Port 0x7FFD is partially decoded on A15 and A1 only.
  localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;

  localparam int BANK_SCREEN0 = 5;
  localparam int BANK_SCREEN1 = 7;
  localparam int BANK_MID     = 2;

  localparam int PG_BANK_LSB = 0;
  localparam int PG_SCREEN   = 3;
  localparam int PG_ROM      = 4;
  localparam int PG_LOCK     = 5;
  localparam int PG_EXT0     = 6;
  localparam int PG_EXT1     = 7;

endpackage

// File: rtl/zx_mem_pager_if.sv
// CPU-side bus and memory-side outputs of the pager, grouped as one interface.
interface zx_mem_pager_if
  import zx_mem_pkg::*;
#(
  parameter int ROM_AW = 15,
  parameter int RAM_AW = 17
) ();

  logic [15:0]       A;
  logic [7:0]        D_in;
  logic              nMREQ;
  logic              nIORQ;
  logic              nRD;
  logic              nWR;
  logic              nM1;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  dbus_sel_e         dbus_sel;
  logic              screen_bank;
  logic [7:0]        page_reg;
  logic              page_locked;
  logic              nWAIT;

  modport master (
    output A, D_in, nMREQ, nIORQ, nRD, nWR, nM1,
    input  rom_addr, ram_addr, ram_we, dbus_sel, screen_bank, page_reg, page_locked, nWAIT
  );

  modport slave (
    input  A, D_in, nMREQ, nIORQ, nRD, nWR, nM1,
    output rom_addr, ram_addr, ram_we, dbus_sel, screen_bank, page_reg, page_locked, nWAIT
  );

endinterface

// File: rtl/zx_wait_gen.sv
// nWAIT stretcher: holds nWAIT low for WAIT_STATES cycles once per memory
// access; WAIT_STATES=0 keeps the FSM parked in IDLE so nWAIT stays high.
module zx_wait_gen #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk_cpu,
  input  logic nreset,
  input  logic nmreq,
  input  logic ram_region,
  input  logic rw_strobe,
  output logic nwait
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit ENABLED = (WAIT_STATES > 0);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_HOLD} wstate_e;

  wstate_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_cpu or negedge nreset) begin
    if (!nreset) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nwait   = 1'b1;
    case (state_q)
      W_IDLE: begin
        if (ENABLED && !nmreq && ram_region && rw_strobe) begin
          state_d = W_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      W_WAIT: begin
        nwait = 1'b0;
        // An aborted access (nMREQ released early) drops the stretch.
        if (nmreq) begin
          state_d = W_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = W_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_HOLD: begin
        if (nmreq) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: rtl/zx_mem_pager.sv
// 128K-style paging latch on port 0x7FFD plus combinational ROM/RAM decode,
// data-bus source select, screen-bank select and optional nWAIT stretching.
module zx_mem_pager
  import zx_mem_pkg::*;
#(
  parameter int RAM_BANKS   = 8,
  parameter int ROM_BANKS   = 2,
  parameter int MODE_128    = 1,
  parameter int WAIT_STATES = 0,
  parameter int BANK_W      = $clog2(RAM_BANKS)
) (
  input  logic           clk_cpu,
  input  logic           nreset,
  zx_mem_pager_if.slave  bus
);

  // Extended bank bits are only writable when the RAM is large enough.
  localparam logic [7:0] PAGE_MASK = {RAM_BANKS == 32, RAM_BANKS >= 16, 6'h3F};

  logic [7:0]        page_q, page_d;
  logic              seen_q, seen_d;
  logic              port_hit;
  logic              mem_rd, mem_wr;
  logic [1:0]        region;
  logic              ram_region;
  logic [4:0]        c000_bank;
  logic [BANK_W-1:0] ram_bank;
  logic              bank_ovf;

  assign port_hit = !bus.nIORQ && !bus.nWR && bus.nM1 &&
                    ((bus.A & PORT_7FFD_MASK) == 16'h0000);

  always_comb begin
    page_d = page_q;
    if (MODE_128 != 0 && port_hit && !seen_q && !page_q[PG_LOCK])
      page_d = bus.D_in & PAGE_MASK;
  end

  // One latch update per IO cycle; the flag clears when nIORQ goes high.
  assign seen_d = !bus.nIORQ && (seen_q || port_hit);

  always_ff @(posedge clk_cpu or negedge nreset) begin
    if (!nreset) begin
      page_q <= 8'h00;
      seen_q <= 1'b0;
    end else begin
      page_q <= page_d;
      seen_q <= seen_d;
    end
  end

  assign region     = bus.A[15:14];
  assign ram_region = (region != 2'd0);
  assign mem_rd     = !bus.nMREQ && !bus.nRD;
  assign mem_wr     = !bus.nMREQ && !bus.nWR && bus.nRD;

  assign c000_bank = (MODE_128 != 0) ?
                     {page_q[PG_EXT1], page_q[PG_EXT0], page_q[PG_BANK_LSB +: 3]} : 5'd0;
  assign bank_ovf  = (region == 2'd3) && ({27'd0, c000_bank} >= 32'(RAM_BANKS));

  always_comb begin
    case (region)
      2'd1:    ram_bank = BANK_W'(BANK_SCREEN0);
      2'd2:    ram_bank = BANK_W'(BANK_MID);
      default: ram_bank = c000_bank[BANK_W-1:0];
    endcase
  end

  generate
    if (ROM_BANKS == 2) begin : g_rom2
      assign bus.rom_addr = {page_q[PG_ROM], bus.A[13:0]};
    end else begin : g_rom1
      assign bus.rom_addr = bus.A[13:0];
    end
  endgenerate

  assign bus.ram_addr = {ram_bank, bus.A[13:0]};
  assign bus.ram_we   = mem_wr && ram_region && !bank_ovf;

  always_comb begin
    bus.dbus_sel = DB_FLOAT;
    if (mem_rd) begin
      if (!ram_region)   bus.dbus_sel = DB_ROM;
      else if (bank_ovf) bus.dbus_sel = DB_FF;
      else               bus.dbus_sel = DB_RAM;
    end
  end

  assign bus.screen_bank = page_q[PG_SCREEN];
  assign bus.page_reg    = page_q;
  assign bus.page_locked = (MODE_128 != 0) ? page_q[PG_LOCK] : 1'b1;

  zx_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait (
    .clk_cpu    (clk_cpu),
    .nreset     (nreset),
    .nmreq      (bus.nMREQ),
    .ram_region (ram_region),
    .rw_strobe  (!bus.nRD || !bus.nWR),
    .nwait      (bus.nWAIT)
  );

  a_no_bank_ovf : assert property (@(posedge clk_cpu) disable iff (!nreset) !bank_ovf);

endmodule
